// File: rtl/ebreak_halt_ctrl.sv
// Halt controller: on a committed EBREAK, freezes fetch, drains for DRAIN_CYCLES, then reports the exit code and halts.
// Trigger to halt_valid takes DRAIN_CYCLES+1 cycles; the report holds with a stable payload until halt_ack.
module ebreak_halt_ctrl #(
  parameter int          XLEN         = 64,
  parameter int          DRAIN_CYCLES = 2,
  parameter logic [31:0] EBREAK_INST  = 32'h00100073
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            commit_valid,
  input  logic            commit_ebreak,
  input  logic [31:0]     commit_inst,
  input  logic [XLEN-1:0] commit_pc,
  input  logic [XLEN-1:0] a0_value,
  input  logic            halt_ack,
  output logic            stall_fetch,
  output logic            halt_valid,
  output logic [XLEN-1:0] halt_code,
  output logic [XLEN-1:0] halt_pc,
  output logic            good_trap,
  output logic            bad_encoding,
  output logic [XLEN-1:0] cycle_cnt,
  output logic [XLEN-1:0] instret_cnt
);

  typedef enum logic [1:0] {RUN, DRAIN, REPORT, HALTED} state_t;

  localparam logic [3:0]      DRAIN_LOAD = 4'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [XLEN-1:0] ONE        = XLEN'(1);

  state_t     state, state_nxt;
  logic [3:0] drain_cnt, drain_cnt_nxt;
  logic       trigger;

  assign trigger     = (state == RUN) && commit_valid && commit_ebreak;
  assign stall_fetch = (state != RUN);
  assign halt_valid  = (state == REPORT);

  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    case (state)
      RUN: begin
        if (trigger) begin
          if (DRAIN_CYCLES > 0) begin
            state_nxt     = DRAIN;
            drain_cnt_nxt = DRAIN_LOAD;
          end else begin
            state_nxt = REPORT;
          end
        end
      end
      DRAIN: begin
        // The counter reading 0 marks the last drain cycle.
        if (drain_cnt == 4'd0) state_nxt = REPORT;
        else                   drain_cnt_nxt = drain_cnt - 4'd1;
      end
      REPORT: begin
        if (halt_ack) state_nxt = HALTED;
      end
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      drain_cnt    <= 4'd0;
      halt_code    <= '0;
      halt_pc      <= '0;
      good_trap    <= 1'b0;
      bad_encoding <= 1'b0;
      cycle_cnt    <= '0;
      instret_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      if (state == RUN || state == DRAIN) cycle_cnt <= cycle_cnt + ONE;
      if (state == RUN && commit_valid)   instret_cnt <= instret_cnt + ONE;
      if (trigger) begin
        halt_code    <= a0_value;
        halt_pc      <= commit_pc;
        bad_encoding <= (commit_inst != EBREAK_INST);
        good_trap    <= (a0_value == '0) && (commit_inst == EBREAK_INST);
      end
    end
  end

endmodule

// File: tb/tb_ebreak_halt_ctrl.sv
// Directed bench: stimulus queues the expected halt report, negedge monitors compare it while halt_valid is high.
// A second instance built with DRAIN_CYCLES=0 and halt_ack tied high checks the one-cycle report.
module tb_ebreak_halt_ctrl;
  localparam logic [31:0] EBRK = 32'h00100073;

  typedef struct {
    logic [63:0] code;
    logic [63:0] pc;
    logic [63:0] cyc;
    logic [63:0] inst;
    logic        good;
    logic        bad;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1, rst0 = 1'b1;
  logic        cv = 1'b0, ce = 1'b0, ack = 1'b0;
  logic [31:0] ci = 32'h0;
  logic [63:0] cpc = '0, a0 = '0;
  logic        cv0 = 1'b0, ce0 = 1'b0;
  logic [63:0] cpc0 = '0;

  logic        stall, hv, good, bad;
  logic [63:0] hcode, hpc, ccnt, icnt;
  logic        stall0, hv0, good0, bad0;
  logic [63:0] hcode0, hpc0, ccnt0, icnt0;

  int   errors = 0, checks = 0, hv0_cycles = 0;
  exp_t q[$], q0[$];
  exp_t cur, cur0;
  logic prev_hv = 1'b0, prev_hv0 = 1'b0;

  always #5 clk = ~clk;

  ebreak_halt_ctrl #(.XLEN(64), .DRAIN_CYCLES(2), .EBREAK_INST(EBRK)) dut (
    .clk(clk), .rst(rst), .commit_valid(cv), .commit_ebreak(ce), .commit_inst(ci),
    .commit_pc(cpc), .a0_value(a0), .halt_ack(ack), .stall_fetch(stall), .halt_valid(hv),
    .halt_code(hcode), .halt_pc(hpc), .good_trap(good), .bad_encoding(bad),
    .cycle_cnt(ccnt), .instret_cnt(icnt)
  );

  ebreak_halt_ctrl #(.XLEN(64), .DRAIN_CYCLES(0), .EBREAK_INST(EBRK)) dut0 (
    .clk(clk), .rst(rst0), .commit_valid(cv0), .commit_ebreak(ce0), .commit_inst(EBRK),
    .commit_pc(cpc0), .a0_value(64'h0), .halt_ack(1'b1), .stall_fetch(stall0), .halt_valid(hv0),
    .halt_code(hcode0), .halt_pc(hpc0), .good_trap(good0), .bad_encoding(bad0),
    .cycle_cnt(ccnt0), .instret_cnt(icnt0)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus on the main instance; inputs are sampled at the next posedge.
  task automatic cyc(input logic v, input logic e, input logic [31:0] inst,
                     input logic [63:0] pc, input logic [63:0] a, input logic k);
    cv = v; ce = e; ci = inst; cpc = pc; a0 = a; ack = k;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 64'h0, 64'h0, 1'b0);
  endtask

  task automatic expect_report(input logic [63:0] code, input logic [63:0] pc, input logic [63:0] c,
                               input logic [63:0] n, input logic g, input logic b);
    exp_t e;
    e.code = code; e.pc = pc; e.cyc = c; e.inst = n; e.good = g; e.bad = b;
    q.push_back(e);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".stall"}, {63'h0, stall}, 64'h0);
    check({tag, ".valid"}, {63'h0, hv}, 64'h0);
    check({tag, ".code"}, hcode, 64'h0);
    check({tag, ".pc"}, hpc, 64'h0);
    check({tag, ".good"}, {63'h0, good}, 64'h0);
    check({tag, ".bad"}, {63'h0, bad}, 64'h0);
    check({tag, ".cycle"}, ccnt, 64'h0);
    check({tag, ".instret"}, icnt, 64'h0);
  endtask

  always @(negedge clk) begin
    if (hv) begin
      if (!prev_hv) begin
        if (q.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_report: halt_valid=1 with no expected report queued");
        end else cur = q.pop_front();
      end
      check("mon.code", hcode, cur.code);
      check("mon.pc", hpc, cur.pc);
      check("mon.cycle", ccnt, cur.cyc);
      check("mon.instret", icnt, cur.inst);
      check("mon.good", {63'h0, good}, {63'h0, cur.good});
      check("mon.bad", {63'h0, bad}, {63'h0, cur.bad});
      check("mon.stall", {63'h0, stall}, 64'h1);
    end
    prev_hv = hv;
  end

  always @(negedge clk) begin
    if (hv0) begin
      hv0_cycles++;
      if (!prev_hv0) begin
        if (q0.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_report0: halt_valid=1 with no expected report queued");
        end else cur0 = q0.pop_front();
      end
      check("mon0.code", hcode0, cur0.code);
      check("mon0.pc", hpc0, cur0.pc);
      check("mon0.cycle", ccnt0, cur0.cyc);
      check("mon0.instret", icnt0, cur0.inst);
      check("mon0.good", {63'h0, good0}, {63'h0, cur0.good});
      check("mon0.bad", {63'h0, bad0}, {63'h0, cur0.bad});
    end
    prev_hv0 = hv0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e0;
    // Basic run: 10 idle, 5 commits, EBREAK with a0=0.
    rst = 1'b1;
    idle(2);
    check_idle_outputs("reset");
    rst = 1'b0;
    idle(10);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 32'h00000013, 64'h80000000 + 64'(4 * i), 64'h7, 1'b0);
    check("run.cycle", ccnt, 64'd15);
    check("run.instret", icnt, 64'd5);
    check("run.stall", {63'h0, stall}, 64'h0);
    expect_report(64'h0, 64'h80000010, 64'd18, 64'd6, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, EBRK, 64'h80000010, 64'h0, 1'b0);
    check("trig.stall", {63'h0, stall}, 64'h1);
    check("trig.valid", {63'h0, hv}, 64'h0);
    idle(1);
    check("drain2.valid", {63'h0, hv}, 64'h0);
    idle(1);
    check("t1.valid_at_3", {63'h0, hv}, 64'h1);
    idle(4);
    cyc(1'b0, 1'b0, 32'h0, 64'h0, 64'h0, 1'b1);
    check("t1.halted_valid", {63'h0, hv}, 64'h0);

    // Slow handshake with a0=1: payload must hold for 20 cycles.
    rst = 1'b1; idle(1); rst = 1'b0;
    expect_report(64'h1, 64'h80000100, 64'd3, 64'd1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, EBRK, 64'h80000100, 64'h1, 1'b0);
    idle(2);
    check("t2.valid", {63'h0, hv}, 64'h1);
    idle(20);
    check("t2.still_valid", {63'h0, hv}, 64'h1);
    cyc(1'b0, 1'b0, 32'h0, 64'h0, 64'h0, 1'b1);
    check("t2.valid_drop", {63'h0, hv}, 64'h0);
    check("t2.halted_stall", {63'h0, stall}, 64'h1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, EBRK, 64'h123, 64'h0, 1'b1);
    check("t2.halted_valid", {63'h0, hv}, 64'h0);
    check("t2.halted_cycle", ccnt, 64'd3);
    check("t2.halted_instret", icnt, 64'd1);
    check("t2.halted_code", hcode, 64'h1);
    check("t2.halted_good", {63'h0, good}, 64'h0);

    // Bad encoding, commits and a second EBREAK during DRAIN, then reset mid-REPORT.
    rst = 1'b1; idle(1); rst = 1'b0;
    cyc(1'b1, 1'b0, 32'h00000013, 64'h800001F8, 64'h0, 1'b0);
    cyc(1'b1, 1'b0, 32'h00000013, 64'h800001FC, 64'h0, 1'b0);
    expect_report(64'h0, 64'h80000200, 64'd5, 64'd3, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 32'h00000073, 64'h80000200, 64'h0, 1'b0);
    cyc(1'b1, 1'b1, EBRK, 64'h80000999, 64'h0, 1'b1);
    cyc(1'b1, 1'b0, 32'h00000013, 64'h80000A00, 64'h9, 1'b1);
    check("t3.valid", {63'h0, hv}, 64'h1);
    idle(3);
    check("t3.hold_valid", {63'h0, hv}, 64'h1);
    rst = 1'b1;
    idle(1);
    check_idle_outputs("midrst");
    rst = 1'b0;

    // Fresh sequence after the reset, acked on the first REPORT cycle.
    idle(3);
    expect_report(64'h5, 64'h80000300, 64'd6, 64'd1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, EBRK, 64'h80000300, 64'h5, 1'b0);
    idle(2);
    check("t5.valid", {63'h0, hv}, 64'h1);
    cyc(1'b0, 1'b0, 32'h0, 64'h0, 64'h0, 1'b1);
    check("t5.valid_drop", {63'h0, hv}, 64'h0);
    check("t5.stall", {63'h0, stall}, 64'h1);

    // Zero-drain instance with halt_ack tied high.
    e0.code = 64'h0; e0.pc = 64'h1000; e0.cyc = 64'd3; e0.inst = 64'd3; e0.good = 1'b1; e0.bad = 1'b0;
    rst0 = 1'b1; @(posedge clk); #1; rst0 = 1'b0;
    cv0 = 1'b1; ce0 = 1'b0; cpc0 = 64'hFF8;
    @(posedge clk); #1; cpc0 = 64'hFFC;
    @(posedge clk); #1;
    q0.push_back(e0);
    ce0 = 1'b1; cpc0 = 64'h1000;
    @(posedge clk); #1;
    cv0 = 1'b0; ce0 = 1'b0;
    check("d0.valid_next", {63'h0, hv0}, 64'h1);
    check("d0.stall", {63'h0, stall0}, 64'h1);
    @(posedge clk); #1;
    check("d0.valid_drop", {63'h0, hv0}, 64'h0);
    repeat (3) @(posedge clk);
    #1;

    check("hv0_cycles", 64'(hv0_cycles), 64'd1);
    check("queue_left", 64'(q.size()), 64'd0);
    check("queue0_left", 64'(q0.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
